matrix_loader: RTL and testbench

- Upstream input stage for the matrix-compute top level: receives a byte stream over a valid/ready handshake and assembles the 4x4 A matrix and the 3x3 B kernel.
- Presents all 25 values as stable parallel 8-bit outputs for the top-level a11..a44 and b11..b33 inputs.
- Issues the run request once a complete frame is loaded, then holds the frame until restarted.

---
 rtl/matrix_loader_if.sv | 31 +++
 rtl/matrix_loader.sv | 199 +++++++++++++++++++
 tb/tb_matrix_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_loader_if
// Byte-stream handshake between a stream source and the matrix loader.
//   in_valid : source has a byte on in_data this cycle
//   in_data  : stream byte, DATA_W bits
//   in_ready : loader can take a byte this cycle
//   restart  : single-cycle request to begin a new frame
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface matrix_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              restart;

    modport master (
        output in_valid,
        output in_data,
        output restart,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  restart,
        output in_ready
    );
endinterface

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Assembles a 4x4 A matrix and a 3x3 B kernel from a byte stream, presents
// all 25 elements as parallel outputs, pulses run for RUN_CYCLES cycles once
// the frame is complete and then holds the frame until restarted.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : stream handshake (in_valid/in_data/in_ready/restart), slave
//   a11..a44   : A matrix elements, row-major (stream bytes 0..15)
//   b11..b33   : B kernel elements, row-major (stream bytes 16..24)
//   run        : run request to the compute top level
//   busy       : high while running or holding a completed frame
//   frame_cnt  : bytes accepted in the current frame, 0..25
// -----------------------------------------------------------------------------
module matrix_loader #(
    parameter int DATA_W     = 8,
    parameter int RUN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    matrix_loader_if.slave    bus,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33,
    output logic              run,
    output logic              busy,
    output logic [4:0]        frame_cnt
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int          N_ELEM   = 25;
    localparam logic [4:0]  LAST_IDX = 5'd24;
    localparam logic [3:0]  RUN_LEN  = 4'(RUN_CYCLES);

    state_t            state_r;
    state_t            next_state_s;
    logic [4:0]        frame_cnt_r;
    logic [3:0]        run_cnt_r;
    logic              run_r;
    logic              busy_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              last_accept_s;
    logic              run_done_s;
    logic [DATA_W-1:0] elem_r [N_ELEM];

    assign accept_s      = bus.in_valid && in_ready_s;
    assign last_accept_s = accept_s && (frame_cnt_r == LAST_IDX);
    assign run_done_s    = (run_cnt_r == RUN_LEN);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; restart is only honoured while loading or holding.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (last_accept_s) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_LOAD;
                end
            end
            S_RUN: begin
                if (run_done_s) begin
                    next_state_s = S_HOLD;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_HOLD: begin
                if (bus.restart) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_HOLD;
                end
            end
            default: begin
                next_state_s = S_LOAD;
            end
        endcase
    end

    // Handshake output; a restart cycle never accepts a byte, and the
    // reset term keeps in_ready low for the whole time reset is asserted.
    always_comb begin
        in_ready_s = 1'b0;
        if (!reset) begin
            in_ready_s = 1'b0;
        end else if ((state_r == S_LOAD) && !bus.restart) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign bus.in_ready = in_ready_s;

    // Frame byte counter: cleared by restart, stepped only on accepted bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= 5'd0;
        end else if (bus.restart && (state_r != S_RUN)) begin
            frame_cnt_r <= 5'd0;
        end else if (accept_s) begin
            frame_cnt_r <= frame_cnt_r + 5'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Run-length counter: loads 1 on the frame-completing accept, then
    // counts run cycles and saturates at RUN_LEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_r <= 4'd0;
        end else if (last_accept_s) begin
            run_cnt_r <= 4'd1;
        end else if ((state_r == S_RUN) && !run_done_s) begin
            run_cnt_r <= run_cnt_r + 4'd1;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Registered run/busy, derived from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            run_r  <= (next_state_s == S_RUN);
            busy_r <= (next_state_s == S_RUN) || (next_state_s == S_HOLD);
        end
    end

    // Element store: accepted byte k lands in element k; others are retained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ELEM; i++) begin
                elem_r[i] <= '0;
            end
        end else if (accept_s) begin
            elem_r[frame_cnt_r] <= bus.in_data;
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                elem_r[i] <= elem_r[i];
            end
        end
    end

    assign a11 = elem_r[0];
    assign a12 = elem_r[1];
    assign a13 = elem_r[2];
    assign a14 = elem_r[3];
    assign a21 = elem_r[4];
    assign a22 = elem_r[5];
    assign a23 = elem_r[6];
    assign a24 = elem_r[7];
    assign a31 = elem_r[8];
    assign a32 = elem_r[9];
    assign a33 = elem_r[10];
    assign a34 = elem_r[11];
    assign a41 = elem_r[12];
    assign a42 = elem_r[13];
    assign a43 = elem_r[14];
    assign a44 = elem_r[15];
    assign b11 = elem_r[16];
    assign b12 = elem_r[17];
    assign b13 = elem_r[18];
    assign b21 = elem_r[19];
    assign b22 = elem_r[20];
    assign b23 = elem_r[21];
    assign b31 = elem_r[22];
    assign b32 = elem_r[23];
    assign b33 = elem_r[24];

    assign run       = run_r;
    assign busy      = busy_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
// Directed bench for matrix_loader. dut1 uses RUN_CYCLES=1 and carries the
// main sequence; dut3 uses RUN_CYCLES=3 for the run-length case. Accepted
// bytes are pushed to a scoreboard queue and popped against the element
// outputs; a small reference model tracks state, count and the matrix.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

    logic clk;
    logic reset;

    matrix_loader_if #(.DATA_W(8)) bus1 ();
    matrix_loader_if #(.DATA_W(8)) bus3 ();

    logic [199:0] mat1;
    logic [199:0] mat3;
    logic         run1, busy1, run3, busy3;
    logic [4:0]   fc1, fc3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] exp_mat [25];
    int         exp_cnt;
    int         exp_st;   // 0 load, 1 run, 2 hold

    matrix_loader #(.DATA_W(8), .RUN_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .a11(mat1[7:0]),     .a12(mat1[15:8]),    .a13(mat1[23:16]),   .a14(mat1[31:24]),
        .a21(mat1[39:32]),   .a22(mat1[47:40]),   .a23(mat1[55:48]),   .a24(mat1[63:56]),
        .a31(mat1[71:64]),   .a32(mat1[79:72]),   .a33(mat1[87:80]),   .a34(mat1[95:88]),
        .a41(mat1[103:96]),  .a42(mat1[111:104]), .a43(mat1[119:112]), .a44(mat1[127:120]),
        .b11(mat1[135:128]), .b12(mat1[143:136]), .b13(mat1[151:144]),
        .b21(mat1[159:152]), .b22(mat1[167:160]), .b23(mat1[175:168]),
        .b31(mat1[183:176]), .b32(mat1[191:184]), .b33(mat1[199:192]),
        .run(run1), .busy(busy1), .frame_cnt(fc1)
    );

    matrix_loader #(.DATA_W(8), .RUN_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave),
        .a11(mat3[7:0]),     .a12(mat3[15:8]),    .a13(mat3[23:16]),   .a14(mat3[31:24]),
        .a21(mat3[39:32]),   .a22(mat3[47:40]),   .a23(mat3[55:48]),   .a24(mat3[63:56]),
        .a31(mat3[71:64]),   .a32(mat3[79:72]),   .a33(mat3[87:80]),   .a34(mat3[95:88]),
        .a41(mat3[103:96]),  .a42(mat3[111:104]), .a43(mat3[119:112]), .a44(mat3[127:120]),
        .b11(mat3[135:128]), .b12(mat3[143:136]), .b13(mat3[151:144]),
        .b21(mat3[159:152]), .b22(mat3[167:160]), .b23(mat3[175:168]),
        .b31(mat3[183:176]), .b32(mat3[191:184]), .b33(mat3[199:192]),
        .run(run3), .busy(busy3), .frame_cnt(fc3)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of dut1 (RUN_CYCLES=1) at one rising edge.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        case (exp_st)
            0: begin
                if (r) begin
                    exp_cnt = 0;
                end else if (v) begin
                    exp_mat[exp_cnt] = d;
                    sb_q.push_back('{exp_cnt, d});
                    exp_cnt++;
                    if (exp_cnt == 25) exp_st = 1;
                end
            end
            1: exp_st = 2;
            default: begin
                if (r) begin
                    exp_st  = 0;
                    exp_cnt = 0;
                end
            end
        endcase
    endtask

    // One clock of dut1 stimulus with handshake and status checks.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bus1.in_valid = v;
        bus1.in_data  = d;
        bus1.restart  = r;
        #1;
        chk("in_ready", {31'd0, bus1.in_ready}, {31'd0, (exp_st == 0) && !r});
        chk("frame_cnt", {27'd0, fc1}, exp_cnt);
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        chk("run", {31'd0, run1}, {31'd0, exp_st == 1});
        chk("busy", {31'd0, busy1}, {31'd0, exp_st != 0});
        bus1.in_valid = 1'b0;
        bus1.restart  = 1'b0;
    endtask

    task automatic flush_sb();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_elem", {24'd0, mat1[e.idx*8 +: 8]}, {24'd0, e.val});
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 25; k++) begin
            chk(tag, {24'd0, mat1[k*8 +: 8]}, {24'd0, exp_mat[k]});
        end
    endtask

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = 8'd0; bus1.restart = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = 8'd0; bus3.restart = 1'b0;
        for (int k = 0; k < 25; k++) exp_mat[k] = 8'd0;
        exp_cnt = 0;
        exp_st  = 0;

        // Reset state.
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus1.in_ready}, 32'd0);
        chk("rst_run", {31'd0, run1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_frame_cnt", {27'd0, fc1}, 32'd0);
        check_all("rst_elem");
        cycle(); cycle();
        chk("rst_in_ready_edge", {31'd0, bus1.in_ready}, 32'd0);
        #2 reset = 1'b1;
        cycle();

        // Full frame 1..25 back-to-back.
        for (int k = 0; k < 25; k++) drive(1'b1, 8'(k + 1), 1'b0);
        chk("f1_run", {31'd0, run1}, 32'd1);
        chk("f1_cnt", {27'd0, fc1}, 32'd25);
        chk("f1_a11", {24'd0, mat1[7:0]}, 32'd1);
        chk("f1_a14", {24'd0, mat1[31:24]}, 32'd4);
        chk("f1_a21", {24'd0, mat1[39:32]}, 32'd5);
        chk("f1_a44", {24'd0, mat1[127:120]}, 32'd16);
        chk("f1_b11", {24'd0, mat1[135:128]}, 32'd17);
        chk("f1_b33", {24'd0, mat1[199:192]}, 32'd25);
        flush_sb();
        drive(1'b0, 8'd0, 1'b0);   // run drops after one cycle, hold follows

        // Hold ignores in_valid.
        for (int i = 0; i < 10; i++) drive(1'b1, 8'hFF, 1'b0);
        check_all("hold_elem");
        chk("hold_cnt", {27'd0, fc1}, 32'd25);

        // Restart from hold; old a11 survives until the first new byte.
        drive(1'b0, 8'd0, 1'b1);
        chk("rs_a11_old", {24'd0, mat1[7:0]}, 32'd1);
        drive(1'b1, 8'h80, 1'b0);
        chk("rs_a11_new", {24'd0, mat1[7:0]}, 32'h80);
        flush_sb();

        // Resync in load, then the same stream with gaps.
        drive(1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 25; k++) begin
            drive(1'b1, 8'(k + 1), 1'b0);
            if (k < 24) drive(1'b0, 8'h5A, 1'b0);
        end
        chk("gap_run", {31'd0, run1}, 32'd1);
        flush_sb();
        check_all("gap_elem");
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1);

        // Restart mid-load at frame_cnt=10 drops the byte offered with it.
        for (int k = 0; k < 10; k++) drive(1'b1, 8'(k + 1), 1'b0);
        flush_sb();
        drive(1'b1, 8'hAA, 1'b1);
        chk("mid_cnt", {27'd0, fc1}, 32'd0);
        drive(1'b1, 8'h33, 1'b0);
        chk("mid_a11", {24'd0, mat1[7:0]}, 32'h33);
        chk("mid_a33", {24'd0, mat1[87:80]}, 32'd11);
        for (int k = 1; k < 20; k++) drive(1'b1, 8'(8'h40 + k), 1'b0);
        chk("pre_rst_cnt", {27'd0, fc1}, 32'd20);
        flush_sb();

        // Asynchronous reset between edges at frame_cnt=20.
        #3 reset = 1'b0;
        #1;
        for (int k = 0; k < 25; k++) exp_mat[k] = 8'd0;
        exp_cnt = 0;
        exp_st  = 0;
        check_all("arst_elem");
        chk("arst_cnt", {27'd0, fc1}, 32'd0);
        chk("arst_in_ready", {31'd0, bus1.in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy1}, 32'd0);
        cycle();
        chk("arst_in_ready_edge", {31'd0, bus1.in_ready}, 32'd0);
        #2 reset = 1'b1;
        cycle();
        drive(1'b0, 8'd0, 1'b0);

        // RUN_CYCLES=3: run for three cycles, restart ignored while running.
        for (int k = 0; k < 25; k++) begin
            bus3.in_valid = 1'b1;
            bus3.in_data  = 8'(100 + k);
            #1;
            chk("r3_in_ready", {31'd0, bus3.in_ready}, 32'd1);
            cycle();
        end
        bus3.in_valid = 1'b0;
        bus3.restart  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("r3_run", {31'd0, run3}, 32'd1);
            chk("r3_busy", {31'd0, busy3}, 32'd1);
            chk("r3_in_ready_run", {31'd0, bus3.in_ready}, 32'd0);
            cycle();
        end
        chk("r3_run_end", {31'd0, run3}, 32'd0);
        chk("r3_busy_hold", {31'd0, busy3}, 32'd1);
        bus3.restart = 1'b0;
        cycle();
        chk("r3_still_hold", {31'd0, busy3}, 32'd1);
        chk("r3_in_ready_hold", {31'd0, bus3.in_ready}, 32'd0);
        chk("r3_cnt", {27'd0, fc3}, 32'd25);
        chk("r3_a11", {24'd0, mat3[7:0]}, 32'd100);
        chk("r3_b33", {24'd0, mat3[199:192]}, 32'd124);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
